// File: rtl/midi_msg_ser.sv
// midi_msg_ser: MIDI message serializer feeding the MIDI TX FIFO write port.
// Takes one packed message {status, d1, d2} per handshake. It decodes the
// message length from the status byte and writes the required bytes into the
// FIFO one at a time. Running-status compression drops a repeated channel
// status byte, and a free-running refresh counter forces the status byte to be
// re-sent once it saturates.
//
// Ports:
//   clk_i       clock
//   rst_n_i     asynchronous active-low reset
//   msg_i       packed message {status[23:16], d1[15:8], d2[7:0]}
//   msg_wr_i    message valid, taken when msg_rdy_o=1
//   msg_rdy_o   serializer idle, ready for a message
//   rs_clr_i    one-cycle pulse invalidating running status
//   byte_o      byte to FIFO wr_data (registered)
//   byte_wr_o   FIFO write strobe
//   byte_rdy_i  FIFO wr_rdy
//   busy_o      message in progress (~msg_rdy_o)
module midi_msg_ser #(
  parameter int MIDI_W       = 8,
  parameter int RS_EN        = 1,
  parameter int RS_REFRESH_W = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [3*MIDI_W-1:0]   msg_i,
  input  logic                  msg_wr_i,
  output logic                  msg_rdy_o,
  input  logic                  rs_clr_i,
  output logic [MIDI_W-1:0]     byte_o,
  output logic                  byte_wr_o,
  input  logic                  byte_rdy_i,
  output logic                  busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STAT = 2'd1;
  localparam logic [1:0] ST_D1   = 2'd2;
  localparam logic [1:0] ST_D2   = 2'd3;

  localparam logic [RS_REFRESH_W-1:0] CNT_MAX = {RS_REFRESH_W{1'b1}};
  localparam logic [RS_REFRESH_W-1:0] CNT_ONE = {{(RS_REFRESH_W-1){1'b0}}, 1'b1};

  logic [1:0]              state_q, state_d;
  logic [1:0]              last_q, last_d;     // final state of the latched byte plan
  logic [MIDI_W-1:0]       d1_q, d1_d;
  logic [MIDI_W-1:0]       d2_q, d2_d;
  logic [MIDI_W-1:0]       byte_q, byte_d;
  logic                    rs_valid_q, rs_valid_d;
  logic [MIDI_W-1:0]       rs_reg_q, rs_reg_d;
  logic [RS_REFRESH_W-1:0] cnt_q, cnt_d;

  logic [MIDI_W-1:0] stat_s;
  logic              accept_s;
  logic              is_chan_s;
  logic              is_sys_s;
  logic              skip_s;
  logic [1:0]        last_s;

  assign stat_s    = msg_i[3*MIDI_W-1 -: MIDI_W];
  assign accept_s  = (state_q == ST_IDLE) && msg_wr_i;
  assign msg_rdy_o = (state_q == ST_IDLE);
  assign busy_o    = (state_q != ST_IDLE);
  assign byte_wr_o = (state_q != ST_IDLE) && byte_rdy_i;
  assign byte_o    = byte_q;

  // Decode message class and the last byte state from the status byte.
  always_comb begin
    is_chan_s = stat_s[7] && (stat_s[7:4] != 4'hF);
    is_sys_s  = (stat_s[7:3] == 5'b11110);
    last_s    = ST_STAT;
    case (stat_s[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: last_s = ST_D2;
      4'hC, 4'hD:                   last_s = ST_D1;
      4'hF: begin
        case (stat_s[3:0])
          4'h1, 4'h3: last_s = ST_D1;
          4'h2:       last_s = ST_D2;
          default:    last_s = ST_STAT;   // F0, F4-F7 and realtime
        endcase
      end
      default: last_s = ST_STAT;          // raw data byte (s < 0x80)
    endcase
    // A coincident rs_clr_i counts as already having invalidated running status.
    skip_s = (RS_EN == 1) && is_chan_s && rs_valid_q && !rs_clr_i &&
             (stat_s == rs_reg_q) && (cnt_q != CNT_MAX);
  end

  // Byte-plan sequencing: latch on accept, advance one byte per FIFO write.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    byte_d  = byte_q;
    if (accept_s) begin
      state_d = skip_s ? ST_D1 : ST_STAT;
      last_d  = last_s;
      d1_d    = msg_i[2*MIDI_W-1 -: MIDI_W];
      d2_d    = msg_i[MIDI_W-1:0];
      byte_d  = skip_s ? msg_i[2*MIDI_W-1 -: MIDI_W] : stat_s;
    end else if ((state_q != ST_IDLE) && byte_rdy_i) begin
      if (state_q == last_q) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_STAT: begin
            state_d = ST_D1;
            byte_d  = d1_q;
          end
          ST_D1: begin
            state_d = ST_D2;
            byte_d  = d2_q;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Running-status tracking and saturating refresh counter.
  always_comb begin
    rs_reg_d = rs_reg_q;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
    if (rs_clr_i) begin
      rs_valid_d = 1'b0;
    end else begin
      rs_valid_d = rs_valid_q;
    end
    if (accept_s) begin
      if (is_chan_s && !skip_s) begin
        rs_reg_d   = stat_s;
        rs_valid_d = 1'b1;
        cnt_d      = {RS_REFRESH_W{1'b0}};
      end else if (is_sys_s) begin
        rs_valid_d = 1'b0;
      end else begin
        rs_valid_d = rs_valid_d;          // data bytes and realtime leave it alone
      end
    end else begin
      rs_reg_d = rs_reg_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      last_q     <= ST_STAT;
      d1_q       <= {MIDI_W{1'b0}};
      d2_q       <= {MIDI_W{1'b0}};
      byte_q     <= {MIDI_W{1'b0}};
      rs_valid_q <= 1'b0;
      rs_reg_q   <= {MIDI_W{1'b0}};
      cnt_q      <= {RS_REFRESH_W{1'b0}};
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      byte_q     <= byte_d;
      rs_valid_q <= rs_valid_d;
      rs_reg_q   <= rs_reg_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_midi_msg_ser.sv
// Directed testbench for midi_msg_ser with a short refresh counter so that
// running-status expiry can be reached quickly.
module tb_midi_msg_ser;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [23:0] msg_i = 24'h000000;
  logic        msg_wr_i = 1'b0;
  logic        msg_rdy_o;
  logic        rs_clr_i = 1'b0;
  logic [7:0]  byte_o;
  logic        byte_wr_o;
  logic        byte_rdy_i = 1'b1;
  logic        busy_o;

  int n_chk  = 0;
  int n_pass = 0;

  midi_msg_ser #(.MIDI_W(8), .RS_EN(1), .RS_REFRESH_W(4)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .msg_i      (msg_i),
    .msg_wr_i   (msg_wr_i),
    .msg_rdy_o  (msg_rdy_o),
    .rs_clr_i   (rs_clr_i),
    .byte_o     (byte_o),
    .byte_wr_o  (byte_wr_o),
    .byte_rdy_i (byte_rdy_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_rdy(input string tag);
    int w;
    w = 0;
    while (!msg_rdy_o && w < 20) begin
      tick();
      w++;
    end
    chk({tag, " rdy"}, {31'd0, msg_rdy_o}, 32'd1);
  endtask

  // Send one message with byte_rdy_i=1 and check bytes, their cycles and ready return.
  task automatic send_msg(input string tag, input logic [23:0] m, input int n,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          input logic clr);
    logic [7:0] b [3];
    int         bc [3];
    int         got;
    int         rdy_c;
    logic [7:0] e;
    wait_rdy(tag);
    msg_i    = m;
    msg_wr_i = 1'b1;
    rs_clr_i = clr;
    tick();
    msg_wr_i = 1'b0;
    rs_clr_i = 1'b0;
    msg_i    = 24'h000000;
    got   = 0;
    rdy_c = 0;
    for (int i = 0; i < 3; i++) begin
      b[i]  = 8'h00;
      bc[i] = 0;
    end
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk_i);
      if (byte_wr_o) begin
        if (got < 3) begin
          b[got]  = byte_o;
          bc[got] = c;
        end
        got++;
      end
      if (msg_rdy_o && rdy_c == 0) rdy_c = c;
      tick();
    end
    chk({tag, " count"}, got, n);
    for (int i = 0; i < n; i++) begin
      e = (i == 0) ? e0 : ((i == 1) ? e1 : e2);
      chk($sformatf("%s byte%0d", tag, i), {24'd0, b[i]}, {24'd0, e});
      chk($sformatf("%s cyc%0d", tag, i), bc[i], i + 1);
    end
    chk({tag, " rdy_cyc"}, rdy_c, n + 1);
  endtask

  initial begin
    // Reset state
    #2;
    @(negedge clk_i);
    chk("rst rdy", {31'd0, msg_rdy_o}, 32'd1);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst wr", {31'd0, byte_wr_o}, 32'd0);
    chk("rst byte", {24'd0, byte_o}, 32'h00);
    tick();
    rst_n_i = 1'b1;
    tick();

    // Full message, then running-status skip, then rs_clr_i variants
    send_msg("note1", 24'h903C64, 3, 8'h90, 8'h3C, 8'h64, 1'b0);
    send_msg("note2", 24'h903E00, 2, 8'h3E, 8'h00, 8'h00, 1'b0);
    rs_clr_i = 1'b1;
    tick();
    rs_clr_i = 1'b0;
    send_msg("clr", 24'h903E00, 3, 8'h90, 8'h3E, 8'h00, 1'b0);
    send_msg("clr_acc", 24'h903E00, 3, 8'h90, 8'h3E, 8'h00, 1'b1);
    send_msg("after_clr", 24'h903E00, 2, 8'h3E, 8'h00, 8'h00, 1'b0);

    // Program change, realtime, program change again (realtime keeps running status)
    send_msg("pc1", 24'hC00511, 2, 8'hC0, 8'h05, 8'h00, 1'b0);
    send_msg("rt", 24'hF81122, 1, 8'hF8, 8'h00, 8'h00, 1'b0);
    send_msg("pc2", 24'hC00733, 1, 8'h07, 8'h00, 8'h00, 1'b0);

    // Refresh expiry with a 4-bit counter
    send_msg("cc1", 24'hB0077F, 3, 8'hB0, 8'h07, 8'h7F, 1'b0);
    send_msg("cc2", 24'hB0077F, 2, 8'h07, 8'h7F, 8'h00, 1'b0);
    repeat (20) tick();
    send_msg("cc_exp", 24'hB0077F, 3, 8'hB0, 8'h07, 8'h7F, 1'b0);

    // Backpressure during D1; a msg_wr_i while busy must be ignored
    wait_rdy("bp");
    msg_i    = 24'hE00040;
    msg_wr_i = 1'b1;
    tick();
    msg_wr_i = 1'b0;
    @(negedge clk_i);
    chk("bp stat_wr", {31'd0, byte_wr_o}, 32'd1);
    chk("bp stat", {24'd0, byte_o}, 32'hE0);
    tick();
    byte_rdy_i = 1'b0;
    msg_i      = 24'h801234;
    msg_wr_i   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk($sformatf("bp stall_wr%0d", i), {31'd0, byte_wr_o}, 32'd0);
      chk($sformatf("bp stall_byte%0d", i), {24'd0, byte_o}, 32'h00);
      chk($sformatf("bp stall_busy%0d", i), {31'd0, busy_o}, 32'd1);
      tick();
    end
    msg_wr_i   = 1'b0;
    msg_i      = 24'h000000;
    byte_rdy_i = 1'b1;
    @(negedge clk_i);
    chk("bp d1_wr", {31'd0, byte_wr_o}, 32'd1);
    chk("bp d1", {24'd0, byte_o}, 32'h00);
    tick();
    @(negedge clk_i);
    chk("bp d2_wr", {31'd0, byte_wr_o}, 32'd1);
    chk("bp d2", {24'd0, byte_o}, 32'h40);
    tick();
    @(negedge clk_i);
    chk("bp done_wr", {31'd0, byte_wr_o}, 32'd0);
    chk("bp done_rdy", {31'd0, msg_rdy_o}, 32'd1);
    tick();

    // Reset asserted after the first byte
    wait_rdy("mrst");
    msg_i    = 24'h903C64;
    msg_wr_i = 1'b1;
    tick();
    msg_wr_i = 1'b0;
    @(negedge clk_i);
    chk("mrst first", {24'd0, byte_o}, 32'h90);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("mrst wr", {31'd0, byte_wr_o}, 32'd0);
    chk("mrst rdy", {31'd0, msg_rdy_o}, 32'd1);
    tick();
    tick();
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk($sformatf("mrst quiet%0d", i), {31'd0, byte_wr_o}, 32'd0);
      tick();
    end
    send_msg("mrst_next", 24'h903C64, 3, 8'h90, 8'h3C, 8'h64, 1'b0);

    // Data byte, system common and SysEx-family messages
    send_msg("data", 24'h421111, 1, 8'h42, 8'h00, 8'h00, 1'b0);
    send_msg("rs_keep", 24'h903C64, 2, 8'h3C, 8'h64, 8'h00, 1'b0);
    send_msg("f3", 24'hF30511, 2, 8'hF3, 8'h05, 8'h00, 1'b0);
    send_msg("rs_sys", 24'h903C64, 3, 8'h90, 8'h3C, 8'h64, 1'b0);
    send_msg("f2", 24'hF21234, 3, 8'hF2, 8'h12, 8'h34, 1'b0);
    send_msg("f6", 24'hF60000, 1, 8'hF6, 8'h00, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/midi_msg_ser.md
# midi_msg_ser

MIDI message serializer that sits directly upstream of the MIDI TX FIFO. It accepts one packed MIDI message per handshake (status plus up to two data bytes) and works out the message length from the status byte. It then writes the required bytes one at a time into the FIFO write port and applies MIDI running-status compression, with a periodic forced status refresh. This lets software issue whole messages instead of polling the FIFO byte by byte.

## Interface

Parameters:
- MIDI_W, 8, byte width; fixed at 8, no other value is supported.
- RS_EN, 1, 1 enables running-status compression; 0 always sends the status byte.
- RS_REFRESH_W, 24, width of the refresh counter; running status expires after 2^RS_REFRESH_W-1 clocks without a sent status byte.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- msg_i  in  24  packed message {status[23:16], d1[15:8], d2[7:0]}.
- msg_wr_i  in  1  message valid; accepted when msg_rdy_o=1.
- msg_rdy_o  out  1  serializer idle and able to accept a message.
- rs_clr_i  in  1  one-cycle pulse that invalidates running status.
- byte_o  out  8  byte to the FIFO wr_data.
- byte_wr_o  out  1  FIFO write strobe.
- byte_rdy_i  in  1  FIFO wr_rdy.
- busy_o  out  1  message in progress; equal to ~msg_rdy_o.

## Operation

- Clock and reset: one clock. Reset is asynchronous, active-low.
- State machine states: IDLE, STAT, D1, D2.
- Accept: a message is accepted when the state is IDLE and msg_wr_i=1. It is latched, and a byte plan is computed from the status byte s:
  - s<0x80: raw data byte (SysEx payload). Send s only. No effect on running status.
  - 0x80–0xBF and 0xE0–0xEF: send status, d1, d2.
  - 0xC0–0xDF: send status, d1.
  - 0xF1 and 0xF3: send status, d1.
  - 0xF2: send status, d1, d2.
  - 0xF0, 0xF4–0xF7: send status only.
  - All of 0xF0–0xF7 clear rs_valid.
  - 0xF8–0xFF (realtime): send status only. No effect on running status or the counter.
- Running-status skip: for a channel message, the status byte is skipped if all of the following hold: RS_EN=1, rs_valid=1, s==rs_reg, and the counter is not saturated. The first state is then D1.
- Running-status update: for a channel message whose status byte is sent, set rs_reg=s, set rs_valid=1, and reset the counter to 0. If the status byte is skipped, rs_reg and the counter are unchanged.
- Counter: increments every clock and saturates at all-ones. Saturated means running status is expired.
- rs_clr_i:
  - Clears rs_valid.
  - If it coincides with an accept, the skip decision treats rs_valid as already 0, so the full status byte is sent and rs_valid is then set by the new message.
  - If it arrives mid-message, the byte plan already latched is unaffected.
- Sending states: in STAT, D1 and D2, byte_o carries the corresponding latched byte. byte_wr_o = (state≠IDLE) & byte_rdy_i. The state advances only when a byte is written. After the last planned byte the state returns to IDLE.
- Backpressure: while byte_rdy_i=0, the state, byte_o and all latched data hold.

## Timing

- Reset values:
  - State IDLE, so msg_rdy_o=1 and busy_o=0.
  - byte_wr_o=0, byte_o=0x00.
  - rs_valid=0, rs_reg=0x00, counter=0.
- Latency: message accepted at edge N; first byte_wr_o in cycle N+1 when byte_rdy_i=1.
- Throughput: k bytes per message take k+1 cycles with no stalls. msg_rdy_o returns high in the cycle after the last byte write.
- byte_wr_o is combinational from registered state and byte_rdy_i. byte_o is registered/latched.
- Reset asserted mid-message: return immediately to IDLE and drop the remaining bytes. No further byte_wr_o.
- msg_wr_i while busy: ignored. Upstream must hold the message until msg_rdy_o=1.

## Test plan

- Reset, then 0x903C64 with byte_rdy_i=1 -> writes 0x90, 0x3C, 0x64 in cycles 1–3; msg_rdy_o=1 in cycle 4.
- 0x903C64 then 0x903E00 -> second message writes only 0x3E, 0x00. Then pulse rs_clr_i and send 0x903E00 -> writes 0x90, 0x3E, 0x00.
- 0xC005xx -> writes 0xC0, 0x05. Then 0xF8xxxx -> writes 0xF8. Then 0xC007xx -> writes 0x07 only, because realtime preserves running status.
- RS_REFRESH_W=4: send 0xB0077F, idle 20 clocks, send 0xB0077F again -> the status byte 0xB0 is re-sent on expiry.
- Hold byte_rdy_i=0 for 5 cycles during D1 of 0xE00040 -> byte_o stays 0x00 and no byte_wr_o; on release writes 0x00, 0x40 with no lost or duplicated bytes.
- Drive rst_n_i low after the first byte of 0x903C64 -> no further writes; msg_rdy_o=1. The next 0x903C64 sends the full 3 bytes, because rs_valid was cleared by reset.
